// File: rtl/multi_debouncer.sv
// Multi-channel debouncer: per-channel synchroniser, counter and filter (lockout or integrate).
// Each channel drives a registered level, one-cycle rise/fall pulses and a busy flag.
module multi_debouncer #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CLK_WAIT    = 20000000,
  parameter int unsigned MODE        = 0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RESET_LEVEL = 0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [CHANNELS-1:0] i_buttons,
  output logic [CHANNELS-1:0] o_signal,
  output logic [CHANNELS-1:0] o_rise,
  output logic [CHANNELS-1:0] o_fall,
  output logic [CHANNELS-1:0] o_busy
);

  localparam int unsigned     CntW   = $clog2(CLK_WAIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_WAIT - 1);
  localparam logic            RstLvl = (RESET_LEVEL != 0);

  typedef enum logic {StIdle, StHold} state_e;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CntW-1:0]        count_q;
    logic                   signal_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   busy_q;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        sync_q <= {SYNC_STAGES{RstLvl}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], i_buttons[ch]};
      end
    end

    assign s = sync_q[SYNC_STAGES-1];

    if (MODE == 0) begin : g_lockout
      state_e state_q;

      // Follow the input at once, then ignore it until the hold interval has elapsed.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          state_q  <= StIdle;
          count_q  <= '0;
          signal_q <= RstLvl;
          rise_q   <= 1'b0;
          fall_q   <= 1'b0;
          busy_q   <= 1'b0;
        end else begin
          rise_q <= 1'b0;
          fall_q <= 1'b0;
          case (state_q)
            StIdle: begin
              if (s != signal_q) begin
                signal_q <= s;
                rise_q   <= s;
                fall_q   <= ~s;
                count_q  <= '0;
                state_q  <= StHold;
                busy_q   <= 1'b1;
              end else begin
                busy_q <= 1'b0;
              end
            end
            StHold: begin
              if (count_q == CntMax) begin
                count_q <= '0;
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end else begin
                count_q <= count_q + CntW'(1);
                busy_q  <= 1'b1;
              end
            end
            default: begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          endcase
        end
      end
    end else begin : g_integrate
      // Accept a new level only after it has been seen on CLK_WAIT consecutive edges.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          count_q  <= '0;
          signal_q <= RstLvl;
          rise_q   <= 1'b0;
          fall_q   <= 1'b0;
          busy_q   <= 1'b0;
        end else begin
          rise_q <= 1'b0;
          fall_q <= 1'b0;
          if (s == signal_q) begin
            count_q <= '0;
            busy_q  <= 1'b0;
          end else if (count_q == CntMax) begin
            signal_q <= s;
            rise_q   <= s;
            fall_q   <= ~s;
            count_q  <= '0;
            busy_q   <= 1'b0;
          end else begin
            count_q <= count_q + CntW'(1);
            busy_q  <= 1'b1;
          end
        end
      end
    end

    assign o_signal[ch] = signal_q;
    assign o_rise[ch]   = rise_q;
    assign o_fall[ch]   = fall_q;
    assign o_busy[ch]   = busy_q;
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: lockout, integrate and reset-level-1 instances side by side,
// checked against a time-based reference model plus directed expectations.
module tb_multi_debouncer;

  localparam int CH   = 4;
  localparam int CW   = 4;
  localparam int SS   = 2;
  localparam int LogN = 64;

  logic          clk = 1'b0;
  logic [2:0]    rst = 3'b111;
  logic [CH-1:0] btn  [3];
  logic [CH-1:0] sig  [3];
  logic [CH-1:0] rise [3];
  logic [CH-1:0] fall [3];
  logic [CH-1:0] busy [3];

  int n_pass   = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  multi_debouncer #(.CHANNELS(CH), .CLK_WAIT(CW), .MODE(0), .SYNC_STAGES(SS), .RESET_LEVEL(0))
  u_lock (.i_clk(clk), .i_rst(rst[0]), .i_buttons(btn[0]), .o_signal(sig[0]),
          .o_rise(rise[0]), .o_fall(fall[0]), .o_busy(busy[0]));

  multi_debouncer #(.CHANNELS(CH), .CLK_WAIT(CW), .MODE(1), .SYNC_STAGES(SS), .RESET_LEVEL(0))
  u_integ (.i_clk(clk), .i_rst(rst[1]), .i_buttons(btn[1]), .o_signal(sig[1]),
           .o_rise(rise[1]), .o_fall(fall[1]), .o_busy(busy[1]));

  multi_debouncer #(.CHANNELS(CH), .CLK_WAIT(CW), .MODE(0), .SYNC_STAGES(SS), .RESET_LEVEL(1))
  u_rl1 (.i_clk(clk), .i_rst(rst[2]), .i_buttons(btn[2]), .o_signal(sig[2]),
         .o_rise(rise[2]), .o_fall(fall[2]), .o_busy(busy[2]));

  // Reference model: pin log indexed by absolute edge number; the filtered input at edge t
  // is the pin sampled SS edges earlier. Lockout = minimum spacing in time, integrate =
  // run length of disagreeing samples.
  int            t = 0;
  int            rst_edge [3];
  int            last_chg [3][CH];
  int            run      [3][CH];
  logic [CH-1:0] e_sig  [3];
  logic [CH-1:0] e_rise [3];
  logic [CH-1:0] e_fall [3];
  logic [CH-1:0] e_busy [3];
  logic          plog [3][CH][LogN];

  function automatic int mode_of(int i);
    return (i == 1) ? 1 : 0;
  endfunction

  function automatic logic rl_of(int i);
    return (i == 2);
  endfunction

  always @(posedge clk) begin : model
    logic       sp;
    logic [5:0] ri;
    logic [5:0] wi;
    t  = t + 1;
    ri = 6'(t - SS);
    wi = 6'(t);
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < CH; c++) begin
        if (rst[i]) begin
          rst_edge[i]  = t;
          e_sig[i][c]  = rl_of(i);
          e_rise[i][c] = 1'b0;
          e_fall[i][c] = 1'b0;
          e_busy[i][c] = 1'b0;
          last_chg[i][c] = -1000;
          run[i][c]      = 0;
        end else begin
          sp = (t - SS > rst_edge[i]) ? plog[i][c][ri] : rl_of(i);
          e_rise[i][c] = 1'b0;
          e_fall[i][c] = 1'b0;
          if (mode_of(i) == 0) begin
            if (sp != e_sig[i][c] && t - last_chg[i][c] > CW) begin
              e_sig[i][c]    = sp;
              e_rise[i][c]   = sp;
              e_fall[i][c]   = ~sp;
              last_chg[i][c] = t;
            end
            e_busy[i][c] = (t - last_chg[i][c] < CW);
          end else begin
            run[i][c] = (sp != e_sig[i][c]) ? run[i][c] + 1 : 0;
            if (run[i][c] == CW) begin
              e_sig[i][c]  = sp;
              e_rise[i][c] = sp;
              e_fall[i][c] = ~sp;
              run[i][c]    = 0;
            end
            e_busy[i][c] = (run[i][c] != 0);
          end
        end
        plog[i][c][wi] = btn[i][c];
      end
    end
  end

  task automatic test_reset;
    logic [CH-1:0] want;
    for (int k = 0; k < 3; k++) begin
      want = (k == 2) ? '1 : '0;
      n_checks++;
      if ({sig[k], rise[k], fall[k], busy[k]} !== {want, {3 * CH{1'b0}}})
        $display("FAIL reset_state inst%0d got sig %b rise %b fall %b busy %b want sig %b, rest 0",
                 k, sig[k], rise[k], fall[k], busy[k], want);
      else n_pass++;
    end
    rst = 3'b000;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      n_checks++;
      if ({sig[2], rise[2], fall[2], busy[2]} !== {{CH{1'b1}}, {3 * CH{1'b0}}})
        $display("FAIL reset_level1 e=%0d got sig %b rise %b fall %b busy %b want 1111/0/0/0",
                 e, sig[2], rise[2], fall[2], busy[2]);
      else n_pass++;
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if ({sig[k], rise[k], fall[k], busy[k]} !== {e_sig[k], e_rise[k], e_fall[k], e_busy[k]})
          $display("FAIL reset_model inst%0d e=%0d got %h want %h", k, e,
                   {sig[k], rise[k], fall[k], busy[k]}, {e_sig[k], e_rise[k], e_fall[k], e_busy[k]});
        else n_pass++;
      end
    end
  endtask

  task automatic test_bounce;
    logic [4:0] seq;
    logic [3:0] got;
    logic [3:0] want;
    seq = 5'b10101;
    btn[0][0] = seq[0];
    for (int e = 1; e <= 14; e++) begin
      @(negedge clk);
      got  = {sig[0][0], rise[0][0], fall[0][0], busy[0][0]};
      want = {e >= 3, e == 3, 1'b0, e >= 3 && e <= 6};
      n_checks++;
      if (got !== want) $display("FAIL bounce e=%0d got %b want %b", e, got, want);
      else n_pass++;
      n_checks++;
      if ({sig[0], rise[0], fall[0], busy[0]} !== {e_sig[0], e_rise[0], e_fall[0], e_busy[0]})
        $display("FAIL bounce_model e=%0d got %h want %h", e,
                 {sig[0], rise[0], fall[0], busy[0]}, {e_sig[0], e_rise[0], e_fall[0], e_busy[0]});
      else n_pass++;
      btn[0][0] = (e < 5) ? seq[e[2:0]] : 1'b1;
    end
  endtask

  task automatic test_glitch;
    logic [3:0] got;
    logic [3:0] want;
    btn[1][1] = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      got = {sig[1][1], rise[1][1], fall[1][1], busy[1][1]};
      if (e <= 10) want = {1'b0, 1'b0, 1'b0, e >= 3 && e <= 5};
      else want = {e - 10 >= 6, e - 10 == 6, 1'b0, e - 10 >= 3 && e - 10 <= 5};
      n_checks++;
      if (got !== want) $display("FAIL glitch e=%0d got %b want %b", e, got, want);
      else n_pass++;
      n_checks++;
      if ({sig[1], rise[1], fall[1], busy[1]} !== {e_sig[1], e_rise[1], e_fall[1], e_busy[1]})
        $display("FAIL glitch_model e=%0d got %h want %h", e,
                 {sig[1], rise[1], fall[1], busy[1]}, {e_sig[1], e_rise[1], e_fall[1], e_busy[1]});
      else n_pass++;
      btn[1][1] = (e < 3) || (e >= 10);
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] got;
    logic [3:0] want;
    btn[0][2] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      got  = {sig[0][2], rise[0][2], fall[0][2], busy[0][2]};
      want = {e == 3 || e >= 7, e == 3 || e == 7, 1'b0, e == 3 || e >= 7};
      n_checks++;
      if (got !== want) $display("FAIL reset_mid e=%0d got %b want %b", e, got, want);
      else n_pass++;
      n_checks++;
      if ({sig[0], rise[0], fall[0], busy[0]} !== {e_sig[0], e_rise[0], e_fall[0], e_busy[0]})
        $display("FAIL reset_mid_model e=%0d got %h want %h", e,
                 {sig[0], rise[0], fall[0], busy[0]}, {e_sig[0], e_rise[0], e_fall[0], e_busy[0]});
      else n_pass++;
      rst[0] = (e == 3);
    end
  endtask

  task automatic test_simultaneous;
    logic [4 * CH-1:0] got;
    logic [4 * CH-1:0] want;
    rst[0] = 1'b1;
    btn[0] = '0;
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    repeat (3) @(negedge clk);
    btn[0] = '1;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      got = {sig[0], rise[0], fall[0], busy[0]};
      if (e <= 12)
        want = {{CH{e >= 3}}, {CH{e == 3}}, {CH{1'b0}}, {CH{e >= 3 && e <= 6}}};
      else
        want = {{CH{e - 12 < 3}}, {CH{1'b0}}, {CH{e - 12 == 3}}, {CH{e - 12 >= 3 && e - 12 <= 6}}};
      n_checks++;
      if (got !== want) $display("FAIL simultaneous e=%0d got %h want %h", e, got, want);
      else n_pass++;
      n_checks++;
      if (got !== {e_sig[0], e_rise[0], e_fall[0], e_busy[0]})
        $display("FAIL simultaneous_model e=%0d got %h want %h", e, got,
                 {e_sig[0], e_rise[0], e_fall[0], e_busy[0]});
      else n_pass++;
      if (e == 12) btn[0] = '0;
    end
  endtask

  task automatic test_spacing;
    logic prev;
    int   last;
    prev = sig[0][3];
    last = -100;
    for (int e = 1; e <= 80; e++) begin
      btn[0][3] = ~btn[0][3];
      @(negedge clk);
      if (sig[0][3] !== prev) begin
        n_checks++;
        if (e - last < CW + 1)
          $display("FAIL spacing e=%0d got gap %0d want at least %0d", e, e - last, CW + 1);
        else n_pass++;
        last = e;
        prev = sig[0][3];
      end
      n_checks++;
      if ({sig[0], rise[0], fall[0], busy[0]} !== {e_sig[0], e_rise[0], e_fall[0], e_busy[0]})
        $display("FAIL spacing_model e=%0d got %h want %h", e,
                 {sig[0], rise[0], fall[0], busy[0]}, {e_sig[0], e_rise[0], e_fall[0], e_busy[0]});
      else n_pass++;
    end
  endtask

  task automatic test_random;
    for (int e = 1; e <= 400; e++) begin
      for (int k = 0; k < 3; k++) begin
        if (e <= 200) btn[k] = btn[k] ^ CH'($urandom & $urandom);
        else btn[k] = btn[k] ^ CH'($urandom & $urandom & $urandom & $urandom);
        rst[k] = ($urandom_range(0, 59) == 0);
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if ({sig[k], rise[k], fall[k], busy[k]} !== {e_sig[k], e_rise[k], e_fall[k], e_busy[k]})
          $display("FAIL random inst%0d e=%0d got %h want %h", k, e,
                   {sig[k], rise[k], fall[k], busy[k]}, {e_sig[k], e_rise[k], e_fall[k], e_busy[k]});
        else n_pass++;
      end
    end
  endtask

  initial begin
    btn[0] = '0;
    btn[1] = '0;
    btn[2] = '1;
    rst    = 3'b111;
    repeat (3) @(negedge clk);
    test_reset;
    test_bounce;
    test_glitch;
    test_reset_mid;
    test_simultaneous;
    test_spacing;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
